// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared funct3 codes, FSM states, error causes and decode helper for the LSU
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SD  = 3'b011;

    localparam logic ERR_MISALIGNED = 1'b0;
    localparam logic ERR_ILLEGAL    = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT_RSP = 2'd2
    } lsu_state_e;

    // funct3[1:0] is log2 of the access size for every legal code, so only legality needs a table
    function automatic logic funct3_legal(input logic we, input logic [2:0] f3, input logic rv64);
        logic ok;
        ok = 1'b0;
        if (we) begin
            ok = (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW) || (rv64 && (f3 == F3_SD));
        end else begin
            ok = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) || (f3 == F3_LBU) ||
                 (f3 == F3_LHU) || (rv64 && ((f3 == F3_LD) || (f3 == F3_LWU)));
        end
        return ok;
    endfunction

endpackage

// File: rtl/lsu_fifo.sv
// rtl/lsu_fifo.sv - synchronous request FIFO with show-ahead head output
module lsu_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;

    // Extra pointer MSB distinguishes full from empty when the index bits match
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    // Advance pointers only on legal push/pop
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push && !full) begin
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (pop && !empty) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    // Pointer registers; reset flushes the queue
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents need no reset because the pointers gate visibility
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/lsu_queued.sv
// rtl/lsu_queued.sv - queued in-order load/store unit with lane alignment and load extension
module lsu_queued
    import lsu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int RA_W  = 6,
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [RA_W-1:0]   req_rd,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN/8-1:0] mem_be,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_rsp_valid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              wb_valid,
    output logic [RA_W-1:0]   wb_rd,
    output logic [XLEN-1:0]   wb_data,
    output logic              err_valid,
    output logic              err_cause,
    output logic [XLEN-1:0]   err_addr,
    output logic              busy
);
    localparam int   BE_W  = XLEN / 8;
    localparam int   OFF_W = $clog2(BE_W);
    localparam logic RV64  = (XLEN == 64);

    typedef struct packed {
        logic            we;
        logic [2:0]      funct3;
        logic [XLEN-1:0] addr;
        logic [RA_W-1:0] rd;
        logic [XLEN-1:0] wdata;
    } lsu_entry_t;

    lsu_entry_t push_e, head_e;
    logic       fifo_full, fifo_empty, fifo_pop;

    lsu_state_e        state_q, state_d;
    logic              pend_we_q, pend_we_d;
    logic [RA_W-1:0]   pend_rd_q, pend_rd_d;
    logic [2:0]        pend_f3_q, pend_f3_d;
    logic [OFF_W-1:0]  pend_off_q, pend_off_d;
    logic              wb_valid_q, wb_valid_d;
    logic [RA_W-1:0]   wb_rd_q, wb_rd_d;
    logic [XLEN-1:0]   wb_data_q, wb_data_d;
    logic              err_valid_q, err_valid_d;
    logic              err_cause_q, err_cause_d;
    logic [XLEN-1:0]   err_addr_q, err_addr_d;

    logic [OFF_W-1:0]  head_off, align_mask;
    logic [BE_W-1:0]   size_be, issue_be;
    logic [XLEN-1:0]   issue_addr, issue_wdata;
    logic              head_illegal, head_misaligned;
    logic [XLEN-1:0]   load_sh, ext_mask, load_ext;
    logic              sign_bit;

    assign push_e    = '{we: req_we, funct3: req_funct3, addr: req_addr, rd: req_rd, wdata: req_wdata};
    assign req_ready = ~fifo_full;

    lsu_fifo #(
        .WIDTH ($bits(lsu_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (req_valid & ~fifo_full),
        .push_data (push_e),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (head_e)
    );

    // Decode the head entry: legality, alignment, byte lanes and shifted store data
    always_comb begin
        head_off   = head_e.addr[OFF_W-1:0];
        align_mask = '0;
        size_be    = '0;
        case (head_e.funct3[1:0])
            2'd0:    begin align_mask = OFF_W'(3'd0); size_be = BE_W'(8'h01); end
            2'd1:    begin align_mask = OFF_W'(3'd1); size_be = BE_W'(8'h03); end
            2'd2:    begin align_mask = OFF_W'(3'd3); size_be = BE_W'(8'h0F); end
            default: begin align_mask = OFF_W'(3'd7); size_be = BE_W'(8'hFF); end
        endcase
        head_illegal    = !funct3_legal(head_e.we, head_e.funct3, RV64);
        head_misaligned = (head_off & align_mask) != '0;
        issue_be        = size_be << head_off;
        issue_wdata     = head_e.wdata << {head_off, 3'b000};
        issue_addr      = {head_e.addr[XLEN-1:OFF_W], {OFF_W{1'b0}}};
    end

    // Extract the addressed lanes of the read data and sign/zero extend to XLEN
    always_comb begin
        load_sh  = mem_rdata >> {pend_off_q, 3'b000};
        ext_mask = '1;
        sign_bit = load_sh[XLEN-1];
        case (pend_f3_q[1:0])
            2'd0:    begin ext_mask = XLEN'(64'h0000_0000_0000_00FF); sign_bit = load_sh[7];  end
            2'd1:    begin ext_mask = XLEN'(64'h0000_0000_0000_FFFF); sign_bit = load_sh[15]; end
            2'd2:    begin ext_mask = XLEN'(64'h0000_0000_FFFF_FFFF); sign_bit = load_sh[31]; end
            default: begin ext_mask = '1; sign_bit = load_sh[XLEN-1]; end
        endcase
        if (pend_f3_q[2]) begin
            sign_bit = 1'b0;
        end
        load_ext = (load_sh & ext_mask) | (sign_bit ? ~ext_mask : '0);
    end

    // Next-state logic: reject bad heads, issue good ones, wait for the response
    always_comb begin
        state_d     = state_q;
        fifo_pop    = 1'b0;
        pend_we_d   = pend_we_q;
        pend_rd_d   = pend_rd_q;
        pend_f3_d   = pend_f3_q;
        pend_off_d  = pend_off_q;
        wb_valid_d  = 1'b0;
        wb_rd_d     = '0;
        wb_data_d   = '0;
        err_valid_d = 1'b0;
        err_cause_d = 1'b0;
        err_addr_d  = '0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    if (head_illegal || head_misaligned) begin
                        fifo_pop    = 1'b1;
                        err_valid_d = 1'b1;
                        err_cause_d = head_illegal ? ERR_ILLEGAL : ERR_MISALIGNED;
                        err_addr_d  = head_e.addr;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (mem_req_ready) begin
                    fifo_pop   = 1'b1;
                    pend_we_d  = head_e.we;
                    pend_rd_d  = head_e.rd;
                    pend_f3_d  = head_e.funct3;
                    pend_off_d = head_off;
                    state_d    = ST_WAIT_RSP;
                end
            end
            ST_WAIT_RSP: begin
                if (mem_rsp_valid) begin
                    state_d = ST_IDLE;
                    if (!pend_we_q && (pend_rd_q != '0)) begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = pend_rd_q;
                        wb_data_d  = load_ext;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, pending-access and output-pulse registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            pend_we_q   <= 1'b0;
            pend_rd_q   <= '0;
            pend_f3_q   <= '0;
            pend_off_q  <= '0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            err_valid_q <= 1'b0;
            err_cause_q <= 1'b0;
            err_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            pend_we_q   <= pend_we_d;
            pend_rd_q   <= pend_rd_d;
            pend_f3_q   <= pend_f3_d;
            pend_off_q  <= pend_off_d;
            wb_valid_q  <= wb_valid_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
            err_valid_q <= err_valid_d;
            err_cause_q <= err_cause_d;
            err_addr_q  <= err_addr_d;
        end
    end

    // Memory request fields come straight from the held head entry and are zero outside ISSUE
    always_comb begin
        mem_req_valid = (state_q == ST_ISSUE);
        mem_we        = mem_req_valid & head_e.we;
        mem_addr      = mem_req_valid ? issue_addr : '0;
        mem_be        = mem_req_valid ? issue_be : '0;
        mem_wdata     = (mem_req_valid && head_e.we) ? issue_wdata : '0;
    end

    assign wb_valid  = wb_valid_q;
    assign wb_rd     = wb_rd_q;
    assign wb_data   = wb_data_q;
    assign err_valid = err_valid_q;
    assign err_cause = err_cause_q;
    assign err_addr  = err_addr_q;
    assign busy      = ~fifo_empty | (state_q != ST_IDLE);

endmodule

// File: tb/tb_lsu_queued.sv
// tb/tb_lsu_queued.sv - directed vector bench for lsu_queued
module tb_lsu_queued;
    localparam int XLEN  = 32;
    localparam int RA_W  = 6;
    localparam int DEPTH = 4;

    logic              clk;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [XLEN-1:0]   req_addr;
    logic [RA_W-1:0]   req_rd;
    logic [XLEN-1:0]   req_wdata;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_we;
    logic [XLEN-1:0]   mem_addr;
    logic [XLEN/8-1:0] mem_be;
    logic [XLEN-1:0]   mem_wdata;
    logic              mem_rsp_valid;
    logic [XLEN-1:0]   mem_rdata;
    logic              wb_valid;
    logic [RA_W-1:0]   wb_rd;
    logic [XLEN-1:0]   wb_data;
    logic              err_valid;
    logic              err_cause;
    logic [XLEN-1:0]   err_addr;
    logic              busy;

    lsu_queued #(.XLEN(XLEN), .RA_W(RA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_rd(req_rd), .req_wdata(req_wdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .err_valid(err_valid), .err_cause(err_cause), .err_addr(err_addr), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [5:0]  rd;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        exp_err;
        logic        exp_cause;
        logic [31:0] exp_maddr;
        logic [3:0]  exp_be;
        logic [31:0] exp_mwdata;
        logic        exp_wb;
        logic [31:0] exp_wbdata;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [5:0] rd, input logic [31:0] wdata);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_rd     = rd;
        req_wdata  = wdata;
    endtask

    task automatic wait_any(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (mem_req_valid || err_valid) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_req(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (mem_req_valid) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
    endtask

    // Wait for an issue, check its address, accept it and return an ack/response
    task automatic serve(input string nm, input logic [31:0] exp_addr, input logic [31:0] rdata);
        bit ok;
        wait_req(20, ok);
        chk({nm, "_seen"}, 64'(ok), 64'd1);
        chk({nm, "_addr"}, 64'(mem_addr), 64'(exp_addr));
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rdata     = rdata;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        mem_rdata     = '0;
    endtask

    task automatic run_vec(input int i, input vec_t v);
        bit ok;
        @(negedge clk);
        set_req(v.we, v.f3, v.addr, v.rd, v.wdata);
        @(negedge clk);
        req_valid = 1'b0;
        wait_any(10, ok);
        chk($sformatf("v%0d_seen", i), 64'(ok), 64'd1);
        if (v.exp_err) begin
            chk($sformatf("v%0d_err_valid", i), 64'(err_valid), 64'd1);
            chk($sformatf("v%0d_err_cause", i), 64'(err_cause), 64'(v.exp_cause));
            chk($sformatf("v%0d_err_addr", i), 64'(err_addr), 64'(v.addr));
            chk($sformatf("v%0d_no_mem", i), 64'(mem_req_valid), 64'd0);
            @(negedge clk);
            chk($sformatf("v%0d_err_pulse", i), 64'(err_valid), 64'd0);
            chk($sformatf("v%0d_no_mem2", i), 64'(mem_req_valid), 64'd0);
            chk($sformatf("v%0d_busy", i), 64'(busy), 64'd0);
        end else begin
            chk($sformatf("v%0d_mem_we", i), 64'(mem_we), 64'(v.we));
            chk($sformatf("v%0d_mem_addr", i), 64'(mem_addr), 64'(v.exp_maddr));
            chk($sformatf("v%0d_mem_be", i), 64'(mem_be), 64'(v.exp_be));
            chk($sformatf("v%0d_mem_wdata", i), 64'(mem_wdata), 64'(v.exp_mwdata));
            mem_req_ready = 1'b1;
            @(negedge clk);
            mem_req_ready = 1'b0;
            mem_rsp_valid = 1'b1;
            mem_rdata     = v.rdata;
            @(negedge clk);
            mem_rsp_valid = 1'b0;
            mem_rdata     = '0;
            chk($sformatf("v%0d_wb_valid", i), 64'(wb_valid), 64'(v.exp_wb));
            if (v.exp_wb) begin
                chk($sformatf("v%0d_wb_rd", i), 64'(wb_rd), 64'(v.rd));
                chk($sformatf("v%0d_wb_data", i), 64'(wb_data), 64'(v.exp_wbdata));
            end
            @(negedge clk);
            chk($sformatf("v%0d_wb_pulse", i), 64'(wb_valid), 64'd0);
            chk($sformatf("v%0d_busy", i), 64'(busy), 64'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // we f3 addr rd wdata rdata | err cause maddr be mwdata wb wbdata
        vecs.push_back('{1'b0, 3'b000, 32'h102, 6'd5, 32'h0,        32'h80FF0000, 1'b0, 1'b0, 32'h100, 4'b0100, 32'h0,        1'b1, 32'hFFFFFFFF});
        vecs.push_back('{1'b0, 3'b100, 32'h102, 6'd5, 32'h0,        32'h80FF0000, 1'b0, 1'b0, 32'h100, 4'b0100, 32'h0,        1'b1, 32'h000000FF});
        vecs.push_back('{1'b1, 3'b001, 32'h206, 6'd0, 32'h0000BEEF, 32'h0,        1'b0, 1'b0, 32'h204, 4'b1100, 32'hBEEF0000, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 3'b010, 32'h301, 6'd2, 32'h0,        32'h0,        1'b1, 1'b0, 32'h0,   4'b0000, 32'h0,        1'b0, 32'h0});
        vecs.push_back('{1'b0, 3'b011, 32'h300, 6'd2, 32'h0,        32'h0,        1'b1, 1'b1, 32'h0,   4'b0000, 32'h0,        1'b0, 32'h0});
        vecs.push_back('{1'b0, 3'b001, 32'h102, 6'd7, 32'h0,        32'h80FF0000, 1'b0, 1'b0, 32'h100, 4'b1100, 32'h0,        1'b1, 32'hFFFF80FF});
        vecs.push_back('{1'b0, 3'b101, 32'h100, 6'd3, 32'h0,        32'h12348001, 1'b0, 1'b0, 32'h100, 4'b0011, 32'h0,        1'b1, 32'h00008001});
        vecs.push_back('{1'b0, 3'b010, 32'h104, 6'd0, 32'h0,        32'h12345678, 1'b0, 1'b0, 32'h104, 4'b1111, 32'h0,        1'b0, 32'h0});
        vecs.push_back('{1'b1, 3'b000, 32'h103, 6'd0, 32'h123456AB, 32'h0,        1'b0, 1'b0, 32'h100, 4'b1000, 32'hAB000000, 1'b0, 32'h0});
        vecs.push_back('{1'b1, 3'b010, 32'h208, 6'd0, 32'hCAFEF00D, 32'h0,        1'b0, 1'b0, 32'h208, 4'b1111, 32'hCAFEF00D, 1'b0, 32'h0});
        vecs.push_back('{1'b1, 3'b010, 32'h202, 6'd0, 32'h1,        32'h0,        1'b1, 1'b0, 32'h0,   4'b0000, 32'h0,        1'b0, 32'h0});
        vecs.push_back('{1'b1, 3'b101, 32'h201, 6'd0, 32'h1,        32'h0,        1'b1, 1'b1, 32'h0,   4'b0000, 32'h0,        1'b0, 32'h0});
        vecs.push_back('{1'b0, 3'b110, 32'h400, 6'd1, 32'h0,        32'h0,        1'b1, 1'b1, 32'h0,   4'b0000, 32'h0,        1'b0, 32'h0});
        vecs.push_back('{1'b0, 3'b000, 32'h101, 6'd9, 32'h0,        32'h00007F00, 1'b0, 1'b0, 32'h100, 4'b0010, 32'h0,        1'b1, 32'h0000007F});
        vecs.push_back('{1'b0, 3'b001, 32'h203, 6'd9, 32'h0,        32'h0,        1'b1, 1'b0, 32'h0,   4'b0000, 32'h0,        1'b0, 32'h0});

        reset = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_rd = '0; req_wdata = '0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_be", 64'(mem_be), 64'd0);
        chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        chk("rst_wb_valid", 64'(wb_valid), 64'd0);
        chk("rst_wb_rd", 64'(wb_rd), 64'd0);
        chk("rst_wb_data", 64'(wb_data), 64'd0);
        chk("rst_err_valid", 64'(err_valid), 64'd0);
        chk("rst_err_cause", 64'(err_cause), 64'd0);
        chk("rst_err_addr", 64'(err_addr), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // Latency: issue at N+2, writeback at M+1, next issue at M+2
        @(negedge clk);
        set_req(1'b0, 3'b010, 32'h400, 6'd4, 32'h0);
        @(negedge clk);
        set_req(1'b0, 3'b010, 32'h404, 6'd8, 32'h0);
        chk("lat_n1_idle", 64'(mem_req_valid), 64'd0);
        @(negedge clk);
        req_valid = 1'b0;
        chk("lat_n2_issue", 64'(mem_req_valid), 64'd1);
        chk("lat_n2_addr", 64'(mem_addr), 64'h400);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rdata = 32'h11223344;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        mem_rdata = '0;
        chk("lat_m1_wb", 64'(wb_valid), 64'd1);
        chk("lat_m1_wb_rd", 64'(wb_rd), 64'd4);
        chk("lat_m1_wb_data", 64'(wb_data), 64'h11223344);
        chk("lat_m1_no_issue", 64'(mem_req_valid), 64'd0);
        @(negedge clk);
        chk("lat_m2_issue", 64'(mem_req_valid), 64'd1);
        chk("lat_m2_addr", 64'(mem_addr), 64'h404);
        serve("lat_second", 32'h404, 32'h0000ABCD);
        chk("lat_second_wb", 64'(wb_valid), 64'd1);
        chk("lat_second_wb_data", 64'(wb_data), 64'h0000ABCD);

        // Backpressure: five back-to-back pushes into a 4-deep queue
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("bp_ready_%0d", k), 64'(req_ready), (k < 4) ? 64'd1 : 64'd0);
            set_req(1'b1, 3'b010, 32'h500 + 32'(4 * k), 6'd0, 32'(k));
        end
        @(negedge clk);
        chk("bp_full_held", 64'(req_ready), 64'd0);
        chk("bp_head_issue", 64'(mem_req_valid), 64'd1);
        chk("bp_head_addr", 64'(mem_addr), 64'h500);
        mem_req_ready = 1'b1;
        @(negedge clk);
        chk("bp_ready_after_pop", 64'(req_ready), 64'd1);
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        mem_rsp_valid = 1'b0;
        for (int k = 1; k < 5; k++) begin
            serve($sformatf("bp_issue_%0d", k), 32'h500 + 32'(4 * k), 32'h0);
        end
        @(negedge clk);
        chk("bp_busy_done", 64'(busy), 64'd0);

        // Error pop and push in the same cycle
        @(negedge clk);
        set_req(1'b0, 3'b010, 32'h301, 6'd2, 32'h0);
        @(negedge clk);
        set_req(1'b0, 3'b010, 32'h600, 6'd0, 32'h0);
        @(negedge clk);
        req_valid = 1'b0;
        chk("ep_err", 64'(err_valid), 64'd1);
        chk("ep_err_addr", 64'(err_addr), 64'h301);
        @(negedge clk);
        chk("ep_issue", 64'(mem_req_valid), 64'd1);
        chk("ep_issue_addr", 64'(mem_addr), 64'h600);
        serve("ep_serve", 32'h600, 32'h55);
        chk("ep_rd0_no_wb", 64'(wb_valid), 64'd0);

        // Reset while waiting for a response abandons the load
        @(negedge clk);
        set_req(1'b0, 3'b010, 32'h700, 6'd6, 32'h0);
        @(negedge clk);
        req_valid = 1'b0;
        begin
            bit ok;
            wait_req(10, ok);
            chk("rs_issue_seen", 64'(ok), 64'd1);
        end
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        chk("rs_busy_wait", 64'(busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        mem_rsp_valid = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        mem_rdata = '0;
        chk("rs_no_wb", 64'(wb_valid), 64'd0);
        chk("rs_busy", 64'(busy), 64'd0);
        chk("rs_req_ready", 64'(req_ready), 64'd1);
        chk("rs_no_issue", 64'(mem_req_valid), 64'd0);
        @(negedge clk);
        chk("rs_no_wb2", 64'(wb_valid), 64'd0);
        chk("rs_busy2", 64'(busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
